// File: rtl/ascon_perm_ctrl.sv
// Iterative Ascon permutation sequencer: applies UNROLL rounds per clock for p^6/p^8/p^12.
// Optional ASCON_PERM_ZEROIZE_EN clears the state register on the output handshake.
module ascon_perm_ctrl #(
  parameter int unsigned UNROLL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_rounds,
  input  logic [63:0] in_x0,
  input  logic [63:0] in_x1,
  input  logic [63:0] in_x2,
  input  logic [63:0] in_x3,
  input  logic [63:0] in_x4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_y0,
  output logic [63:0] out_y1,
  output logic [63:0] out_y2,
  output logic [63:0] out_y3,
  output logic [63:0] out_y4,
  output logic        busy,
  output logic [3:0]  round_idx
);

  localparam int unsigned WORD_W = 64;
  localparam int unsigned CNT_W  = 4;

  if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
    $error("ascon_perm_ctrl: UNROLL must be 1 or 2");
  end

  typedef logic [4:0][WORD_W-1:0] state_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  function automatic logic [WORD_W-1:0] ror64(input logic [WORD_W-1:0] v, input int unsigned n);
    return (v >> n) | (v << (WORD_W - n));
  endfunction

  // Round constant for round r of p^a: k = 12 - a + r, c = {~k, k}.
  function automatic logic [7:0] rc(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] r);
    logic [CNT_W-1:0] k;
    k = (4'd12 - a) + r;
    return {4'hF - k, k};
  endfunction

  function automatic state_t ascon_round(input state_t s, input logic [7:0] c);
    logic [WORD_W-1:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    state_t o;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2] ^ {56'd0, c};
    x3 = s[3];
    x4 = s[4];
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    o[0] = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    o[1] = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    o[2] = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    o[3] = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    o[4] = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    return o;
  endfunction

  fsm_e             fsm_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] r_q, rounds_q;
  logic             in_ready_q, out_valid_q, busy_q;
  logic             last_c;

  // UNROLL chained rounds starting at r_q
  always_comb begin
    state_d = state_q;
    for (int unsigned u = 0; u < UNROLL; u++) begin
      state_d = ascon_round(state_d, rc(rounds_q, r_q + CNT_W'(u)));
    end
  end

  assign last_c = (r_q + CNT_W'(UNROLL)) == rounds_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      r_q         <= '0;
      rounds_q    <= 4'd12;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            state_q    <= {in_x4, in_x3, in_x2, in_x1, in_x0};
            rounds_q   <= (in_rounds == 2'b00) ? 4'd6 : (in_rounds == 2'b01) ? 4'd8 : 4'd12;
            r_q        <= '0;
            fsm_q      <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          state_q <= state_d;
          if (last_c) begin
            r_q         <= '0;
            fsm_q       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            r_q <= r_q + CNT_W'(UNROLL);
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm_q       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef ASCON_PERM_ZEROIZE_EN
            state_q     <= '0;
`else
            state_q     <= state_q;
`endif
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign round_idx = r_q;
  assign out_y0    = state_q[0];
  assign out_y1    = state_q[1];
  assign out_y2    = state_q[2];
  assign out_y3    = state_q[3];
  assign out_y4    = state_q[4];

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Directed bench for ascon_perm_ctrl: UNROLL=1 and UNROLL=2 instances checked against a
// table-driven S-box reference through an expected-result queue.
module tb_ascon_perm_ctrl;

  typedef logic [319:0] st_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [1:0]            in_rounds;
  logic [4:0][63:0]      xin;
  logic [1:0]            in_valid, out_ready, in_ready, out_valid, busy;
  logic [1:0][3:0]       ridx;
  logic [1:0][4:0][63:0] yv;

  int  n_cmp = 0;
  int  n_err = 0;
  st_t sb_q[$];

  logic [4:0] sbox_t [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                              5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                              5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                              5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  int rot_a [5] = '{19, 61, 1, 10, 7};
  int rot_b [5] = '{28, 39, 6, 17, 41};

  ascon_perm_ctrl #(.UNROLL(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_rounds(in_rounds), .in_x0(xin[0]), .in_x1(xin[1]), .in_x2(xin[2]),
    .in_x3(xin[3]), .in_x4(xin[4]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_y0(yv[0][0]), .out_y1(yv[0][1]), .out_y2(yv[0][2]), .out_y3(yv[0][3]),
    .out_y4(yv[0][4]), .busy(busy[0]), .round_idx(ridx[0])
  );

  ascon_perm_ctrl #(.UNROLL(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_rounds(in_rounds), .in_x0(xin[0]), .in_x1(xin[1]), .in_x2(xin[2]),
    .in_x3(xin[3]), .in_x4(xin[4]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_y0(yv[1][0]), .out_y1(yv[1][1]), .out_y2(yv[1][2]), .out_y3(yv[1][3]),
    .out_y4(yv[1][4]), .busy(busy[1]), .round_idx(ridx[1])
  );

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  // Reference permutation: per-bit 5-bit S-box lookup, x0 is the index MSB.
  function automatic st_t model(input logic [4:0][63:0] s, input int a);
    logic [63:0] w [5];
    logic [4:0]  idx, o;
    int          k;
    for (int j = 0; j < 5; j++) w[j] = s[j];
    for (int r = 0; r < a; r++) begin
      k = 12 - a + r;
      w[2][7:0] = w[2][7:0] ^ 8'(((15 - k) << 4) | k);
      for (int i = 0; i < 64; i++) begin
        idx = {w[0][i], w[1][i], w[2][i], w[3][i], w[4][i]};
        o = sbox_t[idx];
        for (int j = 0; j < 5; j++) w[j][i] = o[4-j];
      end
      for (int j = 0; j < 5; j++) w[j] = w[j] ^ rotr(w[j], rot_a[j]) ^ rotr(w[j], rot_b[j]);
    end
    return {w[0], w[1], w[2], w[3], w[4]};
  endfunction

  function automatic st_t get_y(input int u);
    return {yv[u][0], yv[u][1], yv[u][2], yv[u][3], yv[u][4]};
  endfunction

  function automatic int rounds_of(input logic [1:0] code);
    return (code == 2'b00) ? 6 : (code == 2'b01) ? 8 : 12;
  endfunction

  task automatic chk(input string tag, input st_t obs, input st_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_x();
    for (int j = 0; j < 5; j++) xin[j] = {$urandom, $urandom};
  endtask

  function automatic st_t pop_exp();
    if (sb_q.size() == 0) return '1;
    return sb_q.pop_front();
  endfunction

  // One permutation on instance u, with optional back-pressure of hold cycles in DONE.
  task automatic run_one(input int u, input logic [1:0] code, input int hold, input string tag);
    int  a, rr, lat;
    st_t exp;
    a = rounds_of(code);
    rr = a / (u + 1);
    set_x();
    in_rounds = code;
    chk({tag, " in_ready_idle"}, st_t'(in_ready[u]), st_t'(1));
    in_valid[u] = 1'b1;
    sb_q.push_back(model(xin, a));
    tick();
    in_valid[u] = 1'b0;
    set_x();
    in_rounds = ~code;
    chk({tag, " busy_run"}, st_t'(busy[u]), st_t'(1));
    chk({tag, " in_ready_run"}, st_t'(in_ready[u]), st_t'(0));
    lat = 0;
    while (!out_valid[u] && lat < 40) begin
      chk({tag, " round_idx"}, st_t'(ridx[u]), st_t'(lat * (u + 1)));
      tick();
      lat++;
    end
    chk({tag, " latency"}, st_t'(lat), st_t'(rr));
    exp = pop_exp();
    chk({tag, " result"}, get_y(u), exp);
    for (int h = 0; h < hold; h++) begin
      in_valid[u] = (h == 1);
      tick();
      chk({tag, " hold_valid"}, st_t'(out_valid[u]), st_t'(1));
      chk({tag, " hold_y"}, get_y(u), exp);
      chk({tag, " hold_in_ready"}, st_t'(in_ready[u]), st_t'(0));
    end
    in_valid[u] = 1'b0;
    out_ready[u] = 1'b1;
    tick();
    out_ready[u] = 1'b0;
    chk({tag, " post_valid"}, st_t'(out_valid[u]), st_t'(0));
    chk({tag, " post_in_ready"}, st_t'(in_ready[u]), st_t'(1));
    chk({tag, " post_busy"}, st_t'(busy[u]), st_t'(0));
`ifdef ASCON_PERM_ZEROIZE_EN
    chk({tag, " post_y"}, get_y(u), '0);
`else
    chk({tag, " post_y"}, get_y(u), exp);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  acc_t[$];
    int  cyc, nacc, seen, w;
    logic acc;

    rst = 1'b1;
    in_valid = '0;
    out_ready = '0;
    in_rounds = 2'b10;
    set_x();
    tick();
    tick();
    for (int u = 0; u < 2; u++) begin
      chk("rst in_ready", st_t'(in_ready[u]), st_t'(0));
      chk("rst out_valid", st_t'(out_valid[u]), st_t'(0));
      chk("rst busy", st_t'(busy[u]), st_t'(0));
      chk("rst round_idx", st_t'(ridx[u]), st_t'(0));
      chk("rst out_y", get_y(u), '0);
    end
    rst = 1'b0;
    tick();

    run_one(0, 2'b10, 0, "p12_u1");
    run_one(0, 2'b00, 0, "p6_u1");
    run_one(0, 2'b01, 0, "p8_u1");
    run_one(1, 2'b00, 0, "p6_u2");
    run_one(1, 2'b01, 0, "p8_u2");
    run_one(1, 2'b10, 0, "p12_u2");
    run_one(0, 2'b10, 5, "hold_u1");
    run_one(0, 2'b11, 0, "p12rsv_u1");

    // Streaming: in_valid and out_ready held high.
    set_x();
    in_rounds = 2'b10;
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    cyc = 0;
    nacc = 0;
    while (nacc < 4 && cyc < 200) begin
      acc = in_ready[0];
      if (out_valid[0]) chk("stream result", get_y(0), pop_exp());
      if (acc) begin
        sb_q.push_back(model(xin, 12));
        acc_t.push_back(cyc);
        nacc++;
      end
      tick();
      cyc++;
      if (acc) set_x();
    end
    in_valid[0] = 1'b0;
    w = 0;
    while (!out_valid[0] && w < 40) begin
      tick();
      w++;
    end
    chk("stream last result", get_y(0), pop_exp());
    tick();
    out_ready[0] = 1'b0;
    chk("stream accepts", st_t'(nacc), st_t'(4));
    for (int i = 1; i < acc_t.size(); i++)
      chk("stream spacing", st_t'(acc_t[i] - acc_t[i-1]), st_t'(14));

    // Reset during round 5 of p12: no output may appear.
    set_x();
    in_rounds = 2'b10;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    repeat (5) tick();
    chk("midrst round_idx_before", st_t'(ridx[0]), st_t'(5));
    rst = 1'b1;
    tick();
    chk("midrst out_valid", st_t'(out_valid[0]), st_t'(0));
    chk("midrst busy", st_t'(busy[0]), st_t'(0));
    chk("midrst round_idx", st_t'(ridx[0]), st_t'(0));
    chk("midrst out_y", get_y(0), '0);
    rst = 1'b0;
    tick();
    chk("midrst in_ready", st_t'(in_ready[0]), st_t'(1));
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid[0]) seen++;
      tick();
    end
    chk("midrst no_output", st_t'(seen), st_t'(0));
    chk("midrst queue_empty", st_t'(sb_q.size()), st_t'(0));
    run_one(0, 2'b10, 0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ascon_perm_ctrl.md
# ascon_perm_ctrl

Iterative sequencer for the Ascon permutation. The block holds the 320-bit state in a register and applies the existing single-round datapath (constant addition on x2, 5-bit S-box layer, linear diffusion layer) UNROLL times per cycle until p^6, p^8 or p^12 completes. It sits between the mode logic (initialization, associated data, plaintext, finalization) and the round logic. It replaces fully unrolled permutations in area-constrained builds and exposes valid/ready handshakes on both sides.

## Interface
- UNROLL, 1, rounds applied per clock; legal values are 1 and 2. Any other value is an elaboration error.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous and active-high
- in_valid  in  1  input state and in_rounds are valid
- in_ready  out  1  block can accept a state; high only in IDLE
- in_rounds  in  2  round count: 00 = 6, 01 = 8, 10 = 12, 11 = 12 (reserved, treated as 12)
- in_x0..in_x4  in  64 each  input state words
- out_valid  out  1  permuted state available
- out_ready  in  1  consumer accepts the output
- out_y0..out_y4  out  64 each  state register contents; meaningful only while out_valid
- busy  out  1  high in RUN and DONE
- round_idx  out  4  index r (0..a-1) of the first round applied this cycle while in RUN; 0 otherwise

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready = 1. When in_valid && in_ready:
  - load in_x* into the state register;
  - latch a from in_rounds;
  - clear the round counter r to 0;
  - go to RUN.
- RUN: on each edge, apply rounds r .. r+UNROLL-1 in order and set r += UNROLL. When the updated r equals a, go to DONE.
- DONE: out_valid = 1. When out_ready is high, go to IDLE. State is held while out_ready is low.
- Round constant for round r of p^a:
  - k = 12 - a + r;
  - c = ((0xF - k) << 4) | k;
  - c is XORed into bits [7:0] of x2 before the S-box layer.
  - Examples: p12 r=0 gives 0xF0 and r=11 gives 0x4B. p8 r=0 gives 0xB4. p6 r=0 gives 0x96.
- Round count a/UNROLL is always an integer (6, 8, 12 are all even). No partial-round handling exists.
- in_valid while not in IDLE is ignored. The input is not captured, and the source must hold it.
- in_rounds is sampled only on the accept edge. Changes during RUN have no effect.
- Reset mid-operation (rst high in any state):
  - next state IDLE, out_valid 0, busy 0, round_idx 0, r 0;
  - the in-flight permutation is discarded with no output.

## Timing
- Reset values: in_ready 0 during the rst cycle and 1 from the first cycle after. out_valid 0, busy 0, round_idx 0, out_y* 0.
- The accept edge is t0. out_valid rises R = a/UNROLL cycles after t0. Examples:
  - UNROLL=1: p12 = 12, p8 = 8, p6 = 6 cycles;
  - UNROLL=2: p12 = 6, p8 = 4, p6 = 3 cycles.
- Minimum issue interval is R + 2 cycles: one IDLE accept cycle, R RUN cycles, one DONE cycle with out_ready high.
- in_ready is low from the edge after acceptance until the edge after the output handshake.
- out_y* is driven directly from the state register. There is no extra output latency.
- out_valid, once high, stays high until the out_ready handshake or rst. out_y* is stable while out_valid is high.
- The critical path is UNROLL rounds of logic.

## Configuration
- ASCON_PERM_ZEROIZE_EN:
  - Defined: the state register is cleared to all-zero on the edge completing the output handshake (DONE && out_ready). out_y* reads 0 in IDLE.
  - Undefined: the state register retains the last permutation result until the next accept.
- Handshake timing and cycle counts are identical in both builds.

## Test plan
- Reset, then accept a state with in_rounds=10 at UNROLL=1. out_valid rises exactly 12 cycles after accept, and out_y* equals the p12 golden-model result. Trace the x2[7:0] constant sequence 0xF0, 0xE1, …, 0x4B.
- in_rounds=00 (p6) and 01 (p8) at UNROLL=1 and UNROLL=2. Latencies are 6/8 and 3/4 cycles, and results match the model for the same input (first constants 0x96 and 0xB4).
- Hold out_ready=0 for 5 cycles in DONE. out_valid and out_y* stay stable, in_ready stays 0, and a pulsed in_valid is ignored. Release out_ready: IDLE on the next edge, and the next accept proceeds normally.
- Back-to-back streaming with in_valid and out_ready tied high, p12, UNROLL=1. Each accept is spaced exactly 14 cycles apart, and all results are correct.
- Assert rst in round r=5 of p12. The next cycle shows IDLE, out_valid 0, round_idx 0 and in_ready 1, and no output is produced. A fresh permutation afterwards matches the model.
- With ASCON_PERM_ZEROIZE_EN defined, out_y* reads 0 one cycle after the output handshake. Without it, out_y* holds the last result.
